// File: rtl/uart_rx_fifo_pkg.sv
// Shared I/O definitions for the UART receive buffer and the I/O address decoder.
// Holds FIFO depth, status-word bit positions and the UART register offsets.
// Pure definitions: no logic, no latency, no flow control.
package uart_rx_fifo_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  // Status word bit positions seen by the CPU
  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVR    = 2;

  // UART register offsets decoded by the I/O unit
  localparam logic [7:0] UART_DATA_OFS   = 8'h00;
  localparam logic [7:0] UART_STATUS_OFS = 8'h04;
  localparam logic [7:0] UART_CTRL_OFS   = 8'h08;

  function automatic logic [31:0] uart_status(input logic ovr,
                                              input logic is_full,
                                              input logic nempty);
    logic [31:0] s;
    s            = '0;
    s[ST_OVR]    = ovr;
    s[ST_FULL]   = is_full;
    s[ST_NEMPTY] = nempty;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_rise_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
// Latency: combinational pulse, one register of history.  No backpressure.
// Ports: clk, rst (async active-low), din (level in), pulse (din & ~din_q).
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures bytes from the receiver, CPU pops via data-address loads.
// Latency: byte pushed on edge k visible on rd_data/count after edge k; rd_data is show-ahead.
// Backpressure: none to the receiver; a byte arriving while full is dropped and sets sticky overrun.
// Ports: clk, rst (async active-low); rx_data/rx_valid from receiver; rd_en (load strobe),
//        flush, clr_ovr from CPU; rd_data, empty, full, count, overrun, status to the read mux.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_ovr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic [31:0]              status
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              ovr;

  logic push, pop, do_push, do_pop, ovr_evt;

  // Level inputs collapse to a single event on their first cycle high
  rise_pulse u_rx_edge (.clk(clk), .rst(rst), .din(rx_valid), .pulse(push));
  rise_pulse u_rd_edge (.clk(clk), .rst(rst), .din(rd_en),    .pulse(pop));

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is accepted
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_evt = push & full & ~do_pop;

  // Storage is not reset; empty gates rd_data so stale contents never leak out
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
      // A new drop in the same cycle as a clear leaves the flag set
      if (ovr_evt)      ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;
  assign overrun = ovr;
  assign status  = uart_status(ovr, full, ~empty);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART receiver (rx_data_reg / rx_valid) and the I/O read-data mux of the memory-mapped I/O unit. It captures each received byte into a small circular FIFO so the CPU does not lose characters between polling loads. The CPU pops bytes through a load at the UART data address and reads occupancy and error flags through a status word.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2
DATA_W, 8, width of a received character

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
rx_data  in  DATA_W  byte from UART receiver; stable while rx_valid is high
rx_valid  in  1  receiver byte-ready; may be a 1-cycle pulse or a multi-cycle level
rd_en  in  1  CPU load strobe at the UART data address; may be held for several cycles
flush  in  1  synchronous FIFO clear (CPU store to the control address)
clr_ovr  in  1  synchronous clear of the sticky overrun flag
rd_data  out  DATA_W  head-of-FIFO byte (show-ahead); 0 when empty
empty  out  1  no entries
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  current occupancy
overrun  out  1  sticky: at least one byte was dropped because the FIFO was full
status  out  32  {29'b0, overrun, full, !empty}; drives the CPU status read

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overrun=0, and both edge-detect registers=0. Outputs: empty=1, full=0, rd_data=0, status=0. Storage array contents are not reset.
- Push event: push = rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid delayed by one clock. A level held for N cycles produces one push, on the first cycle.
- Pop event: pop = rd_en & ~rd_en_q. One pop per load, whatever the strobe length.
- Effective operations:
  - do_pop = pop & ~empty
  - do_push = push & (~full | do_pop)
- On a clock edge with do_push: mem[wr_ptr] <= rx_data, then wr_ptr increments.
- On a clock edge with do_pop: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous push and pop:
  - When full: both occur; count stays DEPTH, the oldest byte leaves, the new byte enters.
  - When empty: the pop is ignored and the push occurs; count becomes 1.
- Overrun: push & full & ~do_pop sets overrun in that cycle and the byte is dropped. Pointers and count are unchanged.
- clr_ovr clears overrun. If clr_ovr and an overrun event occur in the same cycle, set wins (overrun=1).
- flush:
  - Resets wr_ptr, rd_ptr and count to 0 and clears overrun.
  - Has priority over push, pop and overrun in the same cycle; a byte arriving that cycle is discarded.
  - Edge-detect registers still update.
- rd_data = empty ? 0 : mem[rd_ptr], combinational from registered state. This is zero-latency show-ahead, so the load that pops returns the byte it removes. The pop takes effect at the end of that cycle.
- Latency: a byte pushed on edge k is visible on rd_data and counted after edge k. empty falls in the cycle after the push edge.
- empty and full are derived from count; they are never independent registers.
- Reset asserted mid-operation clears state immediately, with no dependency on clk. On deassertion the FIFO is empty; a rx_valid level already high then causes one push on the first clock edge.

Decomposition:
- Shared I/O package holds:
  - UART_FIFO_DEPTH (16)
  - status bit indices: ST_NEMPTY=0, ST_FULL=1, ST_OVR=2
  - the UART data, status and control address offsets used by the I/O address decoder
- One natural sub-module, rise_pulse: a 1-bit rising-edge detector with clk and active-low async rst. It is instantiated twice, once for rx_valid and once for rd_en.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, full=0, count=0, rd_data=0, status=0.
- Push 0x41, 0x42, 0x43 as 1-cycle pulses, then 3 single-cycle rd_en -> rd_data sequence 0x41, 0x42, 0x43, count goes 3→2→1→0, empty=1 after the last pop.
- Hold rx_valid high 4 cycles with rx_data=0x55, and separately hold rd_en high 3 cycles -> exactly one push (count=1), then exactly one pop (count=0).
- Push 17 bytes 0x00..0x10 with no pops -> full=1 after the 16th, overrun=1 after the 17th, count=16, pops return 0x00..0x0F, and overrun stays 1 until clr_ovr.
- With the FIFO full, push 0xAA and pop in the same cycle -> overrun stays 0, count=16, and after 15 further pops rd_data=0xAA. Run 40 push/pop pairs to exercise pointer wrap with no data corruption.
- Push 5 bytes, then assert flush together with a push of 0x99 -> count=0, empty=1, overrun=0, 0x99 absent. Then assert rst=0 mid-traffic between clock edges -> outputs reach reset values before the next edge.
